// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_prefetch_queue
//  Brief    : Instruction prefetch queue. Keeps one instruction-memory read
//             in flight, buffers {PC, instruction} pairs in a DEPTH-entry
//             circular FIFO and presents the head to the IF/ID register.
//             A redirect flushes the queue and restarts fetching at the new
//             target; a response still in flight at that moment is dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Redirect,
  input  logic [31:0]             RedirectPC,
  output logic                    MemReq,
  output logic [31:0]             MemAddr,
  input  logic                    MemAck,
  input  logic [31:0]             MemRdata,
  output logic                    OutValid,
  output logic [31:0]             OutInstr,
  output logic [31:0]             OutPC,
  input  logic                    OutReady,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int unsigned         c_ptr_w = $clog2(DEPTH);
  localparam int unsigned         c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0]  c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);

  // IDLE : nothing outstanding
  // WAIT : one request outstanding, its data will be queued
  // DRAIN: one request outstanding, its data belongs to a flushed path
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [31:0]          r_fetch_pc;   // address of the next instruction to queue
  logic [31:0]          r_req_addr;   // address of the request in flight
  logic [c_ptr_w-1:0]   r_head;
  logic [c_ptr_w-1:0]   r_tail;
  logic [c_cnt_w-1:0]   r_count;
  logic [31:0]          r_pc_mem    [DEPTH];
  logic [31:0]          r_instr_mem [DEPTH];

  logic                 w_mem_req;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_not_empty;
  logic                 w_unused;

  // The two low bits of a redirect target are forced to zero (word fetch).
  assign w_unused = &{1'b0, RedirectPC[1:0]};

  assign w_not_empty = (r_count != '0);

  // A redirect takes precedence over consuming the head.
  assign w_pop = w_not_empty && OutReady && !Redirect;

  // Next-state and request control. A new request is only launched when the
  // queue has room for its data, so a push can never hit a full queue.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Acks seen here belong to nothing and are ignored. A redirect in
        // this cycle would make FetchPC stale, so the launch waits a cycle.
        if (!Redirect && (r_count < c_depth)) begin
          w_mem_req   = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_mem_req = 1'b1;
        if (MemAck) begin
          w_push      = !Redirect;
          w_state_nxt = ST_IDLE;
        end else if (Redirect) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_mem_req = 1'b1;
        if (MemAck) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request interface: in IDLE the launch address is the live fetch PC; once a
  // request is outstanding the captured address is held even across redirects.
  always_comb begin
    MemReq  = w_mem_req && Rst;
    MemAddr = (r_state == ST_IDLE) ? r_fetch_pc : r_req_addr;
  end

  // Head of the queue, forced to zero when the queue is empty.
  always_comb begin
    OutValid = w_not_empty;
    OutPC    = w_not_empty ? r_pc_mem[r_head]    : 32'h0;
    OutInstr = w_not_empty ? r_instr_mem[r_head] : 32'h0;
    Count    = r_count;
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC advances by one word per queued instruction and jumps on redirect;
  // the request address is latched when a request is launched.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      if (Redirect) begin
        r_fetch_pc <= {RedirectPC[31:2], 2'b00};
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_issue) begin
        r_req_addr <= r_fetch_pc;
      end
    end
  end

  // Circular-buffer pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (Redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_ptr_one;
      end
      if (w_pop) begin
        r_head <= r_head + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only observed through the valid-gated head.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]    <= r_fetch_pc;
      r_instr_mem[r_tail] <= MemRdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_instr_prefetch_queue
//  Brief    : Self-checking bench for instr_prefetch_queue with a queue-based
//             reference model and a second instance for PC wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        MemAck = 1'b0;
  logic [31:0] MemRdata = 32'h0;
  logic        OutReady = 1'b0;

  logic        MemReq, OutValid;
  logic [31:0] MemAddr, OutInstr, OutPC;
  logic [2:0]  Count;

  logic        wr_req, wr_valid;
  logic [31:0] wr_addr, wr_instr, wr_pc;
  logic [2:0]  wr_count;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Rst(Rst), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemRdata(MemRdata),
    .OutValid(OutValid), .OutInstr(OutInstr), .OutPC(OutPC),
    .OutReady(OutReady), .Count(Count)
  );

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .Clk(Clk), .Rst(Rst), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .MemReq(wr_req), .MemAddr(wr_addr), .MemAck(MemAck), .MemRdata(MemRdata),
    .OutValid(wr_valid), .OutInstr(wr_instr), .OutPC(wr_pc),
    .OutReady(OutReady), .Count(wr_count)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (main instance, RESET_PC = 0) ----------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_addr;
  bit          m_out;
  bit          m_drop;

  bit          e_valid, e_req;
  logic [31:0] e_pc, e_instr, e_addr;
  int          e_count;

  function automatic void model_reset();
    q.delete();
    m_fetch = 32'h0;
    m_addr  = 32'h0;
    m_out   = 1'b0;
    m_drop  = 1'b0;
  endfunction

  function automatic void model_expect();
    e_count = q.size();
    e_valid = (e_count != 0);
    e_pc    = e_valid ? q[0].pc    : 32'h0;
    e_instr = e_valid ? q[0].instr : 32'h0;
    e_req   = m_out || ((e_count < DEPTH) && !Redirect);
    e_addr  = m_out ? m_addr : m_fetch;
  endfunction

  function automatic void model_edge();
    bit     pop, take, push, issue;
    entry_t e;
    if (Redirect) begin
      q.delete();
      m_fetch = {RedirectPC[31:2], 2'b00};
      if (m_out) begin
        if (MemAck) begin
          m_out  = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else begin
      pop   = (q.size() != 0) && OutReady;
      take  = m_out && MemAck;
      push  = take && !m_drop;
      issue = !m_out && (q.size() < DEPTH);
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc    = m_fetch;
        e.instr = MemRdata;
        q.push_back(e);
        m_fetch = m_fetch + 32'd4;
      end
      if (take) begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      if (issue) begin
        m_out  = 1'b1;
        m_addr = m_fetch;
      end
    end
  endfunction

  // ---------------- cycle helpers -----------------------------------------
  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input bit redir, input logic [31:0] rpc, input bit ack,
                       input logic [31:0] rd, input bit rdy);
    Redirect   = redir;
    RedirectPC = rpc;
    MemAck     = ack;
    MemRdata   = rd;
    OutReady   = rdy;
    #1;
    model_expect();
  endtask

  task automatic advance();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Rst = 1'b0;
    Redirect = 1'b0; MemAck = 1'b0; OutReady = 1'b0;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    checks++;
    if (Count !== 3'd0 || OutValid !== 1'b0 || MemReq !== 1'b0 || OutPC !== 32'h0 || OutInstr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b req=%b pc=%h instr=%h, want all zero",
               Count, OutValid, MemReq, OutPC, OutInstr);
    end
    model_reset();
    @(negedge Clk);
    Rst = 1'b1;
    drive(0, 32'h0, 0, 32'h0, 0);
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, want 1 00000000", MemReq, MemAddr);
    end
    checks++;
    if (wr_req !== 1'b1 || wr_addr !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL first_req_wrap: req=%b addr=%h, want 1 fffffff8", wr_req, wr_addr);
    end
    advance();
  endtask

  task automatic test_sequence();
    logic [31:0] pcs[$], ins[$], pcs2[$], ins2[$];
    int k = 0;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      drive(0, 32'h0, m_out, 32'hA000_0000 + k, 1);
      checks++;
      if (Count !== 3'(e_count) || Count > 3'd1) begin
        errors++;
        $display("FAIL seq_count c=%0d: got %0d want %0d (max 1)", c, Count, e_count);
      end
      if (c == 4) begin
        checks++;
        if (MemAddr !== 32'h8 || wr_req !== 1'b1 || wr_addr !== 32'h0) begin
          errors++;
          $display("FAIL seq_addr: main=%h wrap=%h req=%b, want 00000008 00000000 1",
                   MemAddr, wr_addr, wr_req);
        end
      end
      if (OutValid) begin pcs.push_back(OutPC);  ins.push_back(OutInstr);  end
      if (wr_valid) begin pcs2.push_back(wr_pc); ins2.push_back(wr_instr); end
      if (m_out) k++;
      advance();
    end
    checks++;
    if (pcs.size() < 3 || pcs[0] !== 32'h0 || pcs[1] !== 32'h4 || pcs[2] !== 32'h8 ||
        ins[0] !== 32'hA000_0000 || ins[1] !== 32'hA000_0001 || ins[2] !== 32'hA000_0002) begin
      errors++;
      $display("FAIL seq_out: got %0d entries first pc=%h, want pcs 0,4,8 instr a0000000..2",
               pcs.size(), (pcs.size() > 0) ? pcs[0] : 32'hx);
    end
    checks++;
    if (pcs2.size() < 3 || pcs2[0] !== 32'hFFFF_FFF8 || pcs2[1] !== 32'hFFFF_FFFC ||
        pcs2[2] !== 32'h0 || ins2[1] !== 32'hA000_0001) begin
      errors++;
      $display("FAIL seq_wrap: got %0d entries first pc=%h, want fffffff8,fffffffc,00000000",
               pcs2.size(), (pcs2.size() > 0) ? pcs2[0] : 32'hx);
    end
  endtask

  task automatic test_fill();
    int k = 0;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      drive(0, 32'h0, m_out, 32'hB000_0000 + k, 0);
      checks++;
      if (Count !== 3'(e_count) || MemReq !== e_req) begin
        errors++;
        $display("FAIL fill_step c=%0d: count=%0d req=%b want %0d %b", c, Count, MemReq, e_count, e_req);
      end
      if (m_out) k++;
      advance();
    end
    drive(0, 32'h0, 0, 32'h0, 1);
    checks++;
    if (Count !== 3'd4 || MemReq !== 1'b0 || OutPC !== 32'h0 || OutInstr !== 32'hB000_0000) begin
      errors++;
      $display("FAIL fill_full: count=%0d req=%b pc=%h instr=%h, want 4 0 00000000 b0000000",
               Count, MemReq, OutPC, OutInstr);
    end
    advance();
    drive(0, 32'h0, 0, 32'h0, 0);
    checks++;
    if (Count !== 3'd3 || MemReq !== 1'b1 || MemAddr !== 32'h10 || OutPC !== 32'h4) begin
      errors++;
      $display("FAIL fill_pop: count=%0d req=%b addr=%h pc=%h, want 3 1 00000010 00000004",
               Count, MemReq, MemAddr, OutPC);
    end
    advance();
    drive(0, 32'h0, 1, 32'hB000_0004, 0);
    advance();
    drive(0, 32'h0, 0, 32'h0, 0);
    checks++;
    if (Count !== 3'd4 || MemReq !== 1'b0) begin
      errors++;
      $display("FAIL fill_refill: count=%0d req=%b, want 4 0", Count, MemReq);
    end
    advance();
  endtask

  task automatic test_redirect_wait();
    bit seen_bad = 1'b0;
    bit first    = 1'b1;
    apply_reset();
    drive(0, 32'h0, 0, 32'h0, 0);           advance();
    drive(0, 32'h0, 1, 32'h1111_1111, 0);   advance();
    drive(0, 32'h0, 0, 32'h0, 0);
    checks++;
    if (Count !== 3'd1 || MemReq !== 1'b1 || MemAddr !== 32'h4) begin
      errors++;
      $display("FAIL redir_pre: count=%0d req=%b addr=%h, want 1 1 00000004", Count, MemReq, MemAddr);
    end
    advance();
    drive(1, 32'h0000_0102, 0, 32'h0, 0);  advance();
    drive(0, 32'h0, 0, 32'h0, 0);
    checks++;
    if (Count !== 3'd0 || OutValid !== 1'b0 || MemReq !== 1'b1 || MemAddr !== 32'h4) begin
      errors++;
      $display("FAIL redir_drain: count=%0d valid=%b req=%b addr=%h, want 0 0 1 00000004",
               Count, OutValid, MemReq, MemAddr);
    end
    advance();
    drive(0, 32'h0, 0, 32'h0, 0);           advance();
    drive(0, 32'h0, 1, 32'hDEAD_BEEF, 1);   advance();
    drive(0, 32'h0, 0, 32'h0, 1);
    checks++;
    if (Count !== 3'd0 || MemReq !== 1'b1 || MemAddr !== 32'h100) begin
      errors++;
      $display("FAIL redir_target: count=%0d req=%b addr=%h, want 0 1 00000100", Count, MemReq, MemAddr);
    end
    advance();
    for (int c = 0; c < 8; c++) begin
      drive(0, 32'h0, m_out, 32'h2222_0000 + c, 1);
      if (OutValid && OutInstr === 32'hDEAD_BEEF) seen_bad = 1'b1;
      if (OutValid && first) begin
        first = 1'b0;
        checks++;
        if (OutPC !== 32'h100) begin
          errors++;
          $display("FAIL redir_first_out: got %h want 00000100", OutPC);
        end
      end
      advance();
    end
    checks++;
    if (seen_bad || first) begin
      errors++;
      $display("FAIL redir_drop: deadbeef_seen=%b no_output=%b, want 0 0", seen_bad, first);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      drive(0, 32'h0, m_out, 32'h3000_0000 + c, 0);
      advance();
    end
    drive(1, 32'h0000_2000, 1, 32'h5555_AAAA, 1);
    checks++;
    if (Count !== 3'd2 || MemReq !== 1'b1 || MemAddr !== 32'h8) begin
      errors++;
      $display("FAIL same_pre: count=%0d req=%b addr=%h, want 2 1 00000008", Count, MemReq, MemAddr);
    end
    advance();
    drive(0, 32'h0, 0, 32'h0, 0);
    checks++;
    if (Count !== 3'd0 || OutValid !== 1'b0 || MemReq !== 1'b1 || MemAddr !== 32'h2000) begin
      errors++;
      $display("FAIL same_post: count=%0d valid=%b req=%b addr=%h, want 0 0 1 00002000",
               Count, OutValid, MemReq, MemAddr);
    end
    advance();
    drive(0, 32'h0, 1, 32'h0000_0077, 0);  advance();
    drive(0, 32'h0, 0, 32'h0, 0);
    checks++;
    if (Count !== 3'd1 || OutPC !== 32'h2000 || OutInstr !== 32'h77) begin
      errors++;
      $display("FAIL same_refetch: count=%0d pc=%h instr=%h, want 1 00002000 00000077",
               Count, OutPC, OutInstr);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(0, 32'h0, 0, 32'h0, 0);  advance();
    drive(0, 32'h0, 0, 32'h0, 0);
    Rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (MemReq !== 1'b0 || Count !== 3'd0) begin
      errors++;
      $display("FAIL midrst_hold: req=%b count=%0d, want 0 0", MemReq, Count);
    end
    @(negedge Clk);
    Rst = 1'b1;
    drive(0, 32'h0, 1, 32'hBAD0_BAD0, 0);
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h0) begin
      errors++;
      $display("FAIL midrst_release: req=%b addr=%h, want 1 00000000", MemReq, MemAddr);
    end
    advance();
    drive(0, 32'h0, 0, 32'h0, 0);
    checks++;
    if (Count !== 3'd0 || OutValid !== 1'b0 || MemReq !== 1'b1 || MemAddr !== 32'h0) begin
      errors++;
      $display("FAIL midrst_nopush: count=%0d valid=%b req=%b addr=%h, want 0 0 1 00000000",
               Count, OutValid, MemReq, MemAddr);
    end
    advance();
    drive(0, 32'h0, 1, 32'h0000_0044, 0);  advance();
    drive(0, 32'h0, 0, 32'h0, 0);
    checks++;
    if (Count !== 3'd1 || OutPC !== 32'h0 || OutInstr !== 32'h44) begin
      errors++;
      $display("FAIL midrst_fetch: count=%0d pc=%h instr=%h, want 1 00000000 00000044",
               Count, OutPC, OutInstr);
    end
    advance();
  endtask

  task automatic test_random();
    bit          redir, ack, rdy;
    logic [31:0] rpc, rd;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom;
      ack   = m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      rd    = $urandom;
      rdy   = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      drive(redir, rpc, ack, rd, rdy);
      checks++;
      if (Count !== 3'(e_count) || OutValid !== e_valid) begin
        errors++;
        $display("FAIL rand_count c=%0d: count=%0d valid=%b want %0d %b", c, Count, OutValid, e_count, e_valid);
      end
      if (e_valid) begin
        checks++;
        if (OutPC !== e_pc || OutInstr !== e_instr) begin
          errors++;
          $display("FAIL rand_head c=%0d: pc=%h instr=%h want %h %h", c, OutPC, OutInstr, e_pc, e_instr);
        end
      end
      checks++;
      if (MemReq !== e_req) begin
        errors++;
        $display("FAIL rand_req c=%0d: got %b want %b", c, MemReq, e_req);
      end
      if (e_req) begin
        checks++;
        if (MemAddr !== e_addr) begin
          errors++;
          $display("FAIL rand_addr c=%0d: got %h want %h", c, MemAddr, e_addr);
        end
      end
      advance();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequence();
    test_fill();
    test_redirect_wait();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
